hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It decides stalls, bubbles and flushes. It works alongside the operand-forwarding logic and covers the cases forwarding cannot resolve: load-use dependencies, taken branches resolved in EX, and multi-cycle data-memory accesses. It also provides a memory-wait watchdog and saturating performance counters, and drives the write enables and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- MEM_TIMEOUT, 64, consecutive not-ready cycles before the watchdog trips (>=2)
- CNT_W, 16, width of each performance counter
- clk  in  1  core clock; everything is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_Rt  in  5  load destination register
- IF_ID_Rs, IF_ID_Rt  in  5 each  source registers of the instruction in ID
- IF_ID_UsesRt  in  1  ID instruction reads Rt (R-type, store, beq/bne)
- EX_Branch_Taken  in  1  branch/jump in EX resolved as taken
- EX_MEM_MemAccess  in  1  instruction in MEM accesses data memory
- dmem_ready  in  1  data memory completes the access this cycle
- PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write  out  1 each  register write enables
- IF_ID_Flush  out  1  load NOP into IF/ID
- ID_EX_Bubble  out  1  load zero controls into ID/EX
- MEM_WB_Bubble  out  1  load zero controls into MEM/WB
- mem_timeout_err  out  1  sticky watchdog error
- load_use_cnt, flush_cnt, freeze_cnt  out  CNT_W each  saturating event/cycle counters

## Operation
- **FSM states:** RUN, WAIT, HALT. Reset state is RUN with the wait counter at 0.
- **Freeze condition:** `freeze = EX_MEM_MemAccess && !dmem_ready`, evaluated in RUN or WAIT.
- **When freeze is true:**
  - All four write enables are 0.
  - MEM_WB_Bubble = 1.
  - IF_ID_Flush = 0 and ID_EX_Bubble = 0.
- **Otherwise, in priority order:**
  1. **Taken branch:** EX_Branch_Taken -> IF_ID_Flush = 1, ID_EX_Bubble = 1, all write enables 1.
  2. **Load-use hazard:** `ID_EX_MemRead && ID_EX_Rt != 0 && (ID_EX_Rt == IF_ID_Rs || (IF_ID_UsesRt && ID_EX_Rt == IF_ID_Rt))` -> PC_Write = 0, IF_ID_Write = 0, ID_EX_Bubble = 1, ID_EX_Write = 1, EX_MEM_Write = 1.
  3. **Default:** all write enables 1, all bubble/flush outputs 0.
- **Deferred events:** a branch or load-use hazard present during a freeze is held in its frozen stage and acted on in the first non-frozen cycle. The block keeps no separate record of it.
- **Transitions:**
  - RUN -> WAIT on freeze; wait counter set to 1.
  - WAIT, freeze, counter < MEM_TIMEOUT-1 -> stay in WAIT, counter increments.
  - WAIT, freeze, counter == MEM_TIMEOUT-1 -> HALT.
  - WAIT, !freeze -> RUN; counter cleared.
  - HALT exits only on reset.
- **HALT behaviour:**
  - All write enables are 0 and MEM_WB_Bubble = 1.
  - mem_timeout_err = 1.
  - dmem_ready is ignored.
- **Counters:** saturate at all-ones and never wrap. Each increments by 1 per cycle in which its condition holds:
  - load_use_cnt: the load-use rule (rule 2) fires.
  - flush_cnt: the branch rule (rule 1) fires.
  - freeze_cnt: freeze is true, or the FSM is in HALT.
- **Register widths:** wait counter is $clog2(MEM_TIMEOUT+1) bits, unsigned.

## Timing
- **Control outputs** are combinational from the current inputs and the registered state, with zero-cycle latency; the pipeline registers sample them on the same edge.
- **Registered outputs:** mem_timeout_err and all counters update on the rising edge after the qualifying cycle.
- **Reset values:**
  - Counters 0, mem_timeout_err 0, state RUN.
  - During reset the combinational outputs follow the RUN rules for the current inputs.
  - Asserting rst_n low mid-WAIT or in HALT returns to RUN immediately (asynchronously).
- **Watchdog timing:** HALT is entered at the end of the MEM_TIMEOUT-th consecutive freeze cycle. If dmem_ready rises in that cycle, the FSM returns to RUN instead.
- **Back-to-back accesses:** a new MEM access that is not ready right after release re-enters WAIT with the counter at 1; waits do not accumulate across accesses.

## Structure
- **Shared package `mips_pkg`:**
  - FSM state encoding: RUN = 2'd0, WAIT = 2'd1, HALT = 2'd2.
  - Register-zero constant.
  - Default MEM_TIMEOUT.
- **Sub-module `sat_counter`** (parameter width, inputs inc/clk/rst_n), instantiated three times.
- **Kept in the top:** FSM and hazard-detection logic.

## Test plan
- **Load-use:** ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; load_use_cnt=1. Repeat with Rt=0 -> no stall.
- **Rt-only dependency:** IF_ID_Rt=8, IF_ID_UsesRt=0 -> no stall. With IF_ID_UsesRt=1 -> stall.
- **Branch:** EX_Branch_Taken=1 -> IF_ID_Flush=1, ID_EX_Bubble=1; flush_cnt=1. Branch plus load-use in the same cycle -> flush only; load_use_cnt unchanged.
- **Memory wait:** EX_MEM_MemAccess=1 with dmem_ready low for 3 cycles and a simultaneous taken branch -> 3 frozen cycles, MEM_WB_Bubble=1, freeze_cnt=3. The flush fires on the 4th cycle.
- **Watchdog:** MEM_TIMEOUT=4, dmem_ready held low -> HALT after 4 cycles, mem_timeout_err=1, enables stay 0 even after dmem_ready=1. A subsequent rst_n pulse clears everything.
- **Saturation:** CNT_W=4 with 20 load-use stalls -> load_use_cnt=15.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core control blocks: hazard FSM encoding,
// register-zero constant and the load-use dependency test.
package mips_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO            = 5'd0;
    localparam int         DEFAULT_MEM_TIMEOUT = 64;

    // $zero is never a real producer, so a load into it cannot create a dependency.
    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        logic rs_dep;
        logic rt_dep;
        rs_dep = (ex_rt == id_rs);
        rt_dep = id_uses_rt && (ex_rt == id_rt);
        return ex_mem_read && (ex_rt != REG_ZERO) && (rs_dep || rt_dep);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: hazard inputs from the
// pipeline registers and the write-enable / bubble / flush controls back to them.
interface hazard_ctrl_if;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_Rt;
    logic [4:0] IF_ID_Rs;
    logic [4:0] IF_ID_Rt;
    logic       IF_ID_UsesRt;
    logic       EX_Branch_Taken;
    logic       EX_MEM_MemAccess;
    logic       dmem_ready;

    logic       PC_Write;
    logic       IF_ID_Write;
    logic       ID_EX_Write;
    logic       EX_MEM_Write;
    logic       IF_ID_Flush;
    logic       ID_EX_Bubble;
    logic       MEM_WB_Bubble;

    modport master (
        output ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt,
               EX_Branch_Taken, EX_MEM_MemAccess, dmem_ready,
        input  PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
               IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt,
               EX_Branch_Taken, EX_MEM_MemAccess, dmem_ready,
        output PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
               IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: advance only when requested and not yet saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, branch flushes,
// data-memory freezes with a wait watchdog, and performance counters.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_ctrl_if.slave       hz,
    output logic               mem_timeout_err,
    output logic [CNT_W-1:0]   load_use_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic [CNT_W-1:0]   freeze_cnt
);

    localparam int              WCW       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    hz_state_e      state_d, state_q;
    logic [WCW-1:0] wcnt_d, wcnt_q;
    logic           err_d, err_q;

    logic freeze_s;
    logic load_use_s;
    logic lu_evt_s;
    logic br_evt_s;
    logic frz_evt_s;

    assign freeze_s   = hz.EX_MEM_MemAccess && !hz.dmem_ready;
    assign load_use_s = load_use_hazard(hz.ID_EX_MemRead, hz.ID_EX_Rt,
                                        hz.IF_ID_Rs, hz.IF_ID_Rt, hz.IF_ID_UsesRt);

    // Next state, wait counter and the pipeline controls for this cycle.
    always_comb begin
        state_d          = state_q;
        wcnt_d           = wcnt_q;
        err_d            = err_q;
        lu_evt_s         = 1'b0;
        br_evt_s         = 1'b0;
        frz_evt_s        = 1'b0;
        hz.PC_Write      = 1'b1;
        hz.IF_ID_Write   = 1'b1;
        hz.ID_EX_Write   = 1'b1;
        hz.EX_MEM_Write  = 1'b1;
        hz.IF_ID_Flush   = 1'b0;
        hz.ID_EX_Bubble  = 1'b0;
        hz.MEM_WB_Bubble = 1'b0;

        case (state_q)
            RUN, WAIT: begin
                if (freeze_s) begin
                    hz.PC_Write      = 1'b0;
                    hz.IF_ID_Write   = 1'b0;
                    hz.ID_EX_Write   = 1'b0;
                    hz.EX_MEM_Write  = 1'b0;
                    hz.MEM_WB_Bubble = 1'b1;
                    frz_evt_s        = 1'b1;
                    if (state_q == RUN) begin
                        state_d = WAIT;
                        wcnt_d  = WCW'(1);
                    end else if (wcnt_q == WAIT_LAST) begin
                        state_d = HALT;
                        err_d   = 1'b1;
                    end else begin
                        wcnt_d  = wcnt_q + WCW'(1);
                    end
                end else begin
                    state_d = RUN;
                    wcnt_d  = {WCW{1'b0}};
                    // Branch squashes the dependent instruction, so it outranks load-use.
                    if (hz.EX_Branch_Taken) begin
                        hz.IF_ID_Flush  = 1'b1;
                        hz.ID_EX_Bubble = 1'b1;
                        br_evt_s        = 1'b1;
                    end else if (load_use_s) begin
                        hz.PC_Write     = 1'b0;
                        hz.IF_ID_Write  = 1'b0;
                        hz.ID_EX_Bubble = 1'b1;
                        lu_evt_s        = 1'b1;
                    end else begin
                        hz.IF_ID_Flush  = 1'b0;
                    end
                end
            end
            HALT: begin
                hz.PC_Write      = 1'b0;
                hz.IF_ID_Write   = 1'b0;
                hz.ID_EX_Write   = 1'b0;
                hz.EX_MEM_Write  = 1'b0;
                hz.MEM_WB_Bubble = 1'b1;
                frz_evt_s        = 1'b1;
            end
            default: begin
                state_d = RUN;
                wcnt_d  = {WCW{1'b0}};
            end
        endcase
    end

    // FSM, wait counter and sticky watchdog flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wcnt_q  <= {WCW{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_timeout_err = err_q;

    sat_counter #(.WIDTH(CNT_W)) u_load_use_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lu_evt_s),
        .count (load_use_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_evt_s),
        .count (flush_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (frz_evt_s),
        .count (freeze_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// against a cycle-level reference model of the stall/flush/watchdog rules.
module tb_hazard_ctrl;

    localparam int MT   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_timeout_err;
    logic [CW-1:0] load_use_cnt;
    logic [CW-1:0] flush_cnt;
    logic [CW-1:0] freeze_cnt;

    hazard_ctrl_if hz();

    hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hz              (hz),
        .mem_timeout_err (mem_timeout_err),
        .load_use_cnt    (load_use_cnt),
        .flush_cnt       (flush_cnt),
        .freeze_cnt      (freeze_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: halted flag, length of the current freeze run, counters.
    bit m_halt;
    bit m_err;
    int m_run;
    int m_lu;
    int m_fl;
    int m_fz;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic bit lu_rule();
        bit dep;
        dep = (hz.ID_EX_Rt == hz.IF_ID_Rs) || (hz.IF_ID_UsesRt && (hz.ID_EX_Rt == hz.IF_ID_Rt));
        return hz.ID_EX_MemRead && (hz.ID_EX_Rt != 5'd0) && dep;
    endfunction

    // Order: PC, IF_ID, ID_EX, EX_MEM write, IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble.
    function automatic logic [6:0] exp_ctl(input bit halted);
        bit frz;
        frz = hz.EX_MEM_MemAccess && !hz.dmem_ready;
        if (halted || frz)          return 7'b0000001;
        if (hz.EX_Branch_Taken)     return 7'b1111110;
        if (lu_rule())              return 7'b0011010;
        return 7'b1111000;
    endfunction

    function automatic logic [6:0] obs_ctl();
        return {hz.PC_Write, hz.IF_ID_Write, hz.ID_EX_Write, hz.EX_MEM_Write,
                hz.IF_ID_Flush, hz.ID_EX_Bubble, hz.MEM_WB_Bubble};
    endfunction

    task automatic model_clear();
        m_halt = 1'b0; m_err = 1'b0; m_run = 0;
        m_lu = 0; m_fl = 0; m_fz = 0;
    endtask

    task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] irt, input logic uses, input logic br,
                         input logic acc, input logic rdy);
        hz.ID_EX_MemRead    = mr;
        hz.ID_EX_Rt         = ert;
        hz.IF_ID_Rs         = rs;
        hz.IF_ID_Rt         = irt;
        hz.IF_ID_UsesRt     = uses;
        hz.EX_Branch_Taken  = br;
        hz.EX_MEM_MemAccess = acc;
        hz.dmem_ready       = rdy;
    endtask

    // One cycle: sample controls at the falling edge, advance the model, cross the rising edge.
    task automatic tick(output logic [6:0] o, output logic [6:0] e);
        bit frz;
        @(negedge clk);
        o   = obs_ctl();
        e   = exp_ctl(m_halt);
        frz = hz.EX_MEM_MemAccess && !hz.dmem_ready;
        if (m_halt) begin
            m_fz = sat(m_fz);
        end else if (frz) begin
            m_fz = sat(m_fz);
            m_run++;
            if (m_run == MT) begin
                m_halt = 1'b1;
                m_err  = 1'b1;
            end
        end else begin
            m_run = 0;
            if (hz.EX_Branch_Taken) m_fl = sat(m_fl);
            else if (lu_rule())     m_lu = sat(m_lu);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] o;
        model_clear();
        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            #3;
            o = obs_ctl();
            checks++;
            if (o !== exp_ctl(1'b0)) begin
                failures++;
                $display("FAIL reset_ctl[%0d] got=%b exp=%b", i, o, exp_ctl(1'b0));
            end
            checks++;
            if ({mem_timeout_err, load_use_cnt, flush_cnt, freeze_cnt} !== {1'b0, 3*CW'(0)}) begin
                failures++;
                $display("FAIL reset_regs[%0d] got err=%b lu=%0d fl=%0d fz=%0d exp all 0",
                         i, mem_timeout_err, load_use_cnt, flush_cnt, freeze_cnt);
            end
        end
        do_reset();
    endtask

    task automatic test_load_use();
        logic [6:0] o, e;
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL load_use_stall got=%b exp=%b", o, e); end
        checks++;
        if (load_use_cnt !== CW'(1)) begin
            failures++; $display("FAIL load_use_cnt got=%0d exp=1", load_use_cnt);
        end
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL load_use_r0 got=%b exp=%b", o, e); end
        checks++;
        if (load_use_cnt !== CW'(m_lu)) begin
            failures++; $display("FAIL load_use_r0_cnt got=%0d exp=%0d", load_use_cnt, m_lu);
        end
    endtask

    task automatic test_rt_only();
        logic [6:0] o, e;
        for (int u = 0; u < 2; u++) begin
            drive(1'b1, 5'd8, 5'd3, 5'd8, 1'(u), 1'b0, 1'b0, 1'b0);
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL rt_only[uses=%0d] got=%b exp=%b", u, o, e); end
        end
        checks++;
        if (load_use_cnt !== CW'(m_lu)) begin
            failures++; $display("FAIL rt_only_cnt got=%0d exp=%0d", load_use_cnt, m_lu);
        end
    endtask

    task automatic test_branch();
        logic [6:0] o, e;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL branch got=%b exp=%b", o, e); end
        checks++;
        if (flush_cnt !== CW'(1)) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", flush_cnt); end
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL branch_lu got=%b exp=%b", o, e); end
        checks++;
        if ({flush_cnt, load_use_cnt} !== {CW'(m_fl), CW'(m_lu)}) begin
            failures++;
            $display("FAIL branch_lu_cnt got fl=%0d lu=%0d exp fl=%0d lu=%0d",
                     flush_cnt, load_use_cnt, m_fl, m_lu);
        end
    endtask

    task automatic test_mem_wait();
        logic [6:0] o, e;
        int fz0;
        fz0 = m_fz;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) hz.dmem_ready = 1'b1;
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL mem_wait[%0d] got=%b exp=%b", i, o, e); end
        end
        checks++;
        if (freeze_cnt !== CW'(fz0 + 3)) begin
            failures++; $display("FAIL mem_wait_fz got=%0d exp=%0d", freeze_cnt, fz0 + 3);
        end
        checks++;
        if (flush_cnt !== CW'(m_fl)) begin
            failures++; $display("FAIL mem_wait_fl got=%0d exp=%0d", flush_cnt, m_fl);
        end
    endtask

    task automatic test_watchdog();
        logic [6:0] o, e;
        // Pattern of dmem_ready per cycle with the access held: 3 waits, release,
        // 3 waits, release, then a full timeout.
        logic [12:0] rdy_pat;
        do_reset();
        rdy_pat = 13'b0000_1000_1000;
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, rdy_pat[i]);
            if (i >= 12) hz.dmem_ready = 1'b1;
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL watchdog[%0d] got=%b exp=%b", i, o, e); end
            checks++;
            if (mem_timeout_err !== m_err) begin
                failures++; $display("FAIL watchdog_err[%0d] got=%b exp=%b", i, mem_timeout_err, m_err);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL halt_hold[%0d] got=%b exp=%b", i, o, e); end
        end
        checks++;
        if ({mem_timeout_err, freeze_cnt} !== {1'b1, CW'(m_fz)}) begin
            failures++;
            $display("FAIL halt_regs got err=%b fz=%0d exp err=1 fz=%0d", mem_timeout_err, freeze_cnt, m_fz);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        o = obs_ctl();
        checks++;
        if ({o, mem_timeout_err, freeze_cnt} !== {exp_ctl(1'b0), 1'b0, CW'(0)}) begin
            failures++;
            $display("FAIL async_reset got ctl=%b err=%b fz=%0d exp ctl=%b err=0 fz=0",
                     o, mem_timeout_err, freeze_cnt, exp_ctl(1'b0));
        end
        do_reset();
    endtask

    task automatic test_saturation();
        logic [6:0] o, e;
        do_reset();
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick(o, e);
        checks++;
        if (load_use_cnt !== CW'(CMAX)) begin
            failures++; $display("FAIL saturation got=%0d exp=%0d", load_use_cnt, CMAX);
        end
    endtask

    task automatic test_random();
        logic [6:0] o, e;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) != 0));
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL random_ctl[%0d] got=%b exp=%b", i, o, e); end
            checks++;
            if ({mem_timeout_err, load_use_cnt, flush_cnt, freeze_cnt} !==
                {m_err, CW'(m_lu), CW'(m_fl), CW'(m_fz)}) begin
                failures++;
                $display("FAIL random_regs[%0d] got err=%b lu=%0d fl=%0d fz=%0d exp err=%b lu=%0d fl=%0d fz=%0d",
                         i, mem_timeout_err, load_use_cnt, flush_cnt, freeze_cnt,
                         m_err, m_lu, m_fl, m_fz);
            end
            if (m_halt && ($urandom_range(0, 3) == 0)) do_reset();
        end
    endtask

    initial begin
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_load_use();
        test_rt_only();
        test_branch();
        test_mem_wait();
        test_watchdog();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
